// File: rtl/register_file_arbiter_if.sv
// Command/response bundle between host, coprocessor, arbiter and register_file.
// The arbiter takes the slave view; whoever drives requesters and the memory takes master.
interface register_file_arbiter_if #(
   parameter int size          = 6,
   parameter int cell_width    = 32,
   parameter int width         = cell_width * size,
   parameter int address_width = $clog2(size * size)
) ();
   logic                     in_h_req;
   logic                     in_h_write;
   logic [address_width-1:0] in_h_address;
   logic [1:0]               in_h_type;
   logic [1:0]               in_h_matrix;
   logic [width-1:0]         in_h_data;
   logic                     out_h_grant;
   logic [width-1:0]         out_h_rdata;
   logic                     out_h_rvalid;
   logic                     out_h_err;

   logic                     in_p_req;
   logic                     in_p_write;
   logic [address_width-1:0] in_p_address;
   logic [1:0]               in_p_type;
   logic [1:0]               in_p_matrix;
   logic [width-1:0]         in_p_data;
   logic                     out_p_grant;
   logic [width-1:0]         out_p_rdata;
   logic                     out_p_rvalid;
   logic                     out_p_err;

   logic [address_width-1:0] out_reg_address;
   logic [width-1:0]         out_reg_data;
   logic [1:0]               out_reg_type;
   logic [1:0]               out_reg_matrix;
   logic                     out_reg_read_en;
   logic                     out_reg_write_en;
   logic [width-1:0]         in_reg_data;

   modport slave (
      input  in_h_req, in_h_write, in_h_address, in_h_type, in_h_matrix, in_h_data,
      output out_h_grant, out_h_rdata, out_h_rvalid, out_h_err,
      input  in_p_req, in_p_write, in_p_address, in_p_type, in_p_matrix, in_p_data,
      output out_p_grant, out_p_rdata, out_p_rvalid, out_p_err,
      output out_reg_address, out_reg_data, out_reg_type, out_reg_matrix,
      output out_reg_read_en, out_reg_write_en,
      input  in_reg_data
   );

   modport master (
      output in_h_req, in_h_write, in_h_address, in_h_type, in_h_matrix, in_h_data,
      input  out_h_grant, out_h_rdata, out_h_rvalid, out_h_err,
      output in_p_req, in_p_write, in_p_address, in_p_type, in_p_matrix, in_p_data,
      input  out_p_grant, out_p_rdata, out_p_rvalid, out_p_err,
      input  out_reg_address, out_reg_data, out_reg_type, out_reg_matrix,
      input  out_reg_read_en, out_reg_write_en,
      output in_reg_data
   );
endinterface

// File: rtl/register_file_arbiter.sv
// Round-robin owner of the single register_file port shared by host loader and coprocessor.
// Bursts are bounded to max_burst accesses whenever the other side is waiting.
module register_file_arbiter #(
   parameter int size          = 6,
   parameter int cell_width    = 32,
   parameter int width         = cell_width * size,
   parameter int address_width = $clog2(size * size),
   parameter int max_burst     = 4
) (
   input logic                    in_clk,
   input logic                    in_reset,
   register_file_arbiter_if.slave bus
);
   localparam int cnt_w = $clog2(max_burst + 1);

   typedef enum logic [1:0] {IDLE, OWN_H, OWN_P} state_t;

   state_t             state_q;
   logic               h_grant_q, p_grant_q;
   logic               ptr_q;            // 1: coprocessor wins the next tie
   logic [cnt_w-1:0]   cnt_q, cnt_d;
   logic               tag_valid_q, tag_q; // tag_q 1: pending read belongs to coprocessor
   logic               h_err_q, p_err_q;

   logic                     own_h, own_p;
   logic                     sel_req, sel_write, other_req, legal, access;
   logic [address_width-1:0] sel_address;
   logic [1:0]               sel_type, sel_matrix;
   logic [width-1:0]         sel_data;
   logic                     take_h, take_p, release_port;

   always_comb begin
      own_h       = (state_q == OWN_H);
      own_p       = (state_q == OWN_P);
      sel_req     = (own_h & bus.in_h_req) | (own_p & bus.in_p_req);
      sel_write   = own_p ? bus.in_p_write   : bus.in_h_write;
      sel_address = own_p ? bus.in_p_address : bus.in_h_address;
      sel_type    = own_p ? bus.in_p_type    : bus.in_h_type;
      sel_matrix  = own_p ? bus.in_p_matrix  : bus.in_h_matrix;
      sel_data    = own_p ? bus.in_p_data    : bus.in_h_data;
      other_req   = own_h ? bus.in_p_req     : bus.in_h_req;
      legal       = (sel_matrix != 2'b11) && (sel_type != 2'b11);
      access      = sel_req & legal;
      cnt_d       = (access && cnt_q != cnt_w'(max_burst)) ? cnt_q + cnt_w'(1) : cnt_q;
   end

   always_comb begin
      take_h       = 1'b0;
      take_p       = 1'b0;
      release_port = 1'b0;
      case (state_q)
         IDLE: begin
            take_h = bus.in_h_req & (~bus.in_p_req | ~ptr_q);
            take_p = bus.in_p_req & ~take_h;
         end
         OWN_H: begin
            take_p       = other_req & (~sel_req | (access & (cnt_d == cnt_w'(max_burst))));
            release_port = ~sel_req & ~other_req;
         end
         OWN_P: begin
            take_h       = other_req & (~sel_req | (access & (cnt_d == cnt_w'(max_burst))));
            release_port = ~sel_req & ~other_req;
         end
         default: release_port = 1'b1;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state_q     <= IDLE;
         h_grant_q   <= 1'b0;
         p_grant_q   <= 1'b0;
         ptr_q       <= 1'b0;
         cnt_q       <= '0;
         tag_valid_q <= 1'b0;
         tag_q       <= 1'b0;
         h_err_q     <= 1'b0;
         p_err_q     <= 1'b0;
      end else begin
         tag_valid_q <= access & ~sel_write;
         tag_q       <= own_p;
         h_err_q     <= own_h & bus.in_h_req & ~legal;
         p_err_q     <= own_p & bus.in_p_req & ~legal;
         if (take_h) begin
            state_q   <= OWN_H;
            h_grant_q <= 1'b1;
            p_grant_q <= 1'b0;
            ptr_q     <= 1'b1;
            cnt_q     <= '0;
         end else if (take_p) begin
            state_q   <= OWN_P;
            h_grant_q <= 1'b0;
            p_grant_q <= 1'b1;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
         end else if (release_port) begin
            state_q   <= IDLE;
            h_grant_q <= 1'b0;
            p_grant_q <= 1'b0;
            cnt_q     <= '0;
         end else begin
            cnt_q     <= cnt_d;
         end
      end
   end

   assign bus.out_reg_read_en  = access & ~sel_write;
   assign bus.out_reg_write_en = access & sel_write;
   assign bus.out_reg_address  = access ? sel_address : '0;
   assign bus.out_reg_type     = access ? sel_type    : '0;
   assign bus.out_reg_matrix   = access ? sel_matrix  : '0;
   assign bus.out_reg_data     = (access & sel_write) ? sel_data : '0;

   // Return path follows the issuer tag, not the current owner.
   assign bus.out_h_grant  = h_grant_q;
   assign bus.out_p_grant  = p_grant_q;
   assign bus.out_h_rvalid = tag_valid_q & ~tag_q;
   assign bus.out_p_rvalid = tag_valid_q & tag_q;
   assign bus.out_h_rdata  = (tag_valid_q & ~tag_q) ? bus.in_reg_data : '0;
   assign bus.out_p_rdata  = (tag_valid_q & tag_q)  ? bus.in_reg_data : '0;
   assign bus.out_h_err    = h_err_q;
   assign bus.out_p_err    = p_err_q;
endmodule

// File: tb/tb_register_file_arbiter.sv
// Directed vector table for register_file_arbiter with a behavioural register_file
// behind it, plus a hand sequence for reset in the middle of a burst.
module tb_register_file_arbiter;
   localparam int W  = 192;
   localparam int AW = 6;

   logic in_clk = 1'b0;
   logic in_reset = 1'b0;
   always #5 in_clk = ~in_clk;

   register_file_arbiter_if bus ();

   register_file_arbiter dut (
      .in_clk  (in_clk),
      .in_reset(in_reset),
      .bus     (bus)
   );

   // Behavioural register_file: one-cycle registered read.
   logic [W-1:0] mem [0:3][0:63];
   always @(posedge in_clk) begin
      if (bus.out_reg_write_en) mem[bus.out_reg_matrix][bus.out_reg_address] <= bus.out_reg_data;
      if (bus.out_reg_read_en)  bus.in_reg_data <= mem[bus.out_reg_matrix][bus.out_reg_address];
   end

   typedef struct {
      bit rst;
      bit hr, hw; logic [1:0] hm; logic [AW-1:0] ha;
      bit pr, pw; logic [1:0] pm; logic [AW-1:0] pa;
      bit hg, pg, ren, wen; logic [1:0] em; logic [AW-1:0] ea;
      bit hv, pv, pe;
   } vec_t;

   vec_t vq[$];
   int total = 0;
   int bad   = 0;

   function automatic logic [W-1:0] data_of(input logic [1:0] m, input logic [AW-1:0] a);
      logic [W-1:0] d;
      for (int c = 0; c < 6; c++) d[c*32 +: 32] = {16'hC0DE, 4'(c), 2'b00, m, 2'b00, a};
      return d;
   endfunction

   function automatic vec_t mk(bit rst, bit hr, bit hw, int hm, int ha, bit pr, bit pw, int pm, int pa,
                               bit hg, bit pg, bit ren, bit wen, int em, int ea, bit hv, bit pv, bit pe);
      vec_t v;
      v.rst = rst; v.hr = hr; v.hw = hw; v.hm = 2'(hm); v.ha = AW'(ha);
      v.pr = pr; v.pw = pw; v.pm = 2'(pm); v.pa = AW'(pa);
      v.hg = hg; v.pg = pg; v.ren = ren; v.wen = wen; v.em = 2'(em); v.ea = AW'(ea);
      v.hv = hv; v.pv = pv; v.pe = pe;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.in_h_req     = v.hr;
      bus.in_h_write   = v.hw;
      bus.in_h_matrix  = v.hm;
      bus.in_h_address = v.ha;
      bus.in_h_type    = 2'b01;
      bus.in_h_data    = data_of(v.hm, v.ha);
      bus.in_p_req     = v.pr;
      bus.in_p_write   = v.pw;
      bus.in_p_matrix  = v.pm;
      bus.in_p_address = v.pa;
      bus.in_p_type    = 2'b10;
      bus.in_p_data    = ~data_of(v.pm, v.pa);
   endtask

   task automatic check_vec(input vec_t v, input int idx, input logic [W-1:0] rd_exp);
      logic         en;
      logic [W-1:0] wdat;
      logic [1:0]   ty;
      en   = v.ren | v.wen;
      wdat = !v.wen ? '0 : (v.hg ? data_of(v.em, v.ea) : ~data_of(v.em, v.ea));
      ty   = !en ? 2'b00 : (v.hg ? 2'b01 : 2'b10);
      chk("h_grant",  idx, W'(bus.out_h_grant),      W'(v.hg));
      chk("p_grant",  idx, W'(bus.out_p_grant),      W'(v.pg));
      chk("read_en",  idx, W'(bus.out_reg_read_en),  W'(v.ren));
      chk("write_en", idx, W'(bus.out_reg_write_en), W'(v.wen));
      chk("address",  idx, W'(bus.out_reg_address),  en ? W'(v.ea) : '0);
      chk("matrix",   idx, W'(bus.out_reg_matrix),   en ? W'(v.em) : '0);
      chk("type",     idx, W'(bus.out_reg_type),     W'(ty));
      chk("reg_data", idx, bus.out_reg_data,         wdat);
      chk("h_rvalid", idx, W'(bus.out_h_rvalid),     W'(v.hv));
      chk("p_rvalid", idx, W'(bus.out_p_rvalid),     W'(v.pv));
      chk("h_rdata",  idx, bus.out_h_rdata,          v.hv ? rd_exp : '0);
      chk("p_rdata",  idx, bus.out_p_rdata,          v.pv ? rd_exp : '0);
      chk("h_err",    idx, W'(bus.out_h_err),        '0);
      chk("p_err",    idx, W'(bus.out_p_err),        W'(v.pe));
      $display("vec %0d: hg=%0b pg=%0b ren=%0b wen=%0b mat=%0d addr=%0d hv=%0b pv=%0b pe=%0b",
               idx, bus.out_h_grant, bus.out_p_grant, bus.out_reg_read_en, bus.out_reg_write_en,
               bus.out_reg_matrix, bus.out_reg_address, bus.out_h_rvalid, bus.out_p_rvalid, bus.out_p_err);
   endtask

   initial begin
      logic [W-1:0] rd_exp;
      vec_t z;
      int k;

      // Host alone: 18 row writes then 18 readbacks, coprocessor silent.
      vq.push_back(mk(1, 1,1,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));
      for (int m = 0; m < 3; m++)
         for (int r = 0; r < 6; r++)
            vq.push_back(mk(0, 1,1,m,6*r, 0,0,0,0, 1,0,0,1,m,6*r, 0,0,0));
      k = 0;
      for (int m = 0; m < 3; m++)
         for (int r = 0; r < 6; r++) begin
            vq.push_back(mk(0, 1,0,m,6*r, 0,0,0,0, 1,0,1,0,m,6*r, k > 0,0,0));
            k++;
         end
      vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0,0,0,0,0, 1,0,0));
      vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));

      // Both requesting from reset: H x4, P x4, H x4, back-to-back.
      vq.push_back(mk(1, 1,1,0,1, 1,1,2,10, 0,0,0,0,0,0, 0,0,0));
      for (int i = 0; i < 4; i++) vq.push_back(mk(0, 1,1,0,1+i, 1,1,2,10, 1,0,0,1,0,1+i, 0,0,0));
      for (int i = 0; i < 4; i++) vq.push_back(mk(0, 1,1,0,5, 1,1,2,10+i, 0,1,0,1,2,10+i, 0,0,0));
      for (int i = 0; i < 4; i++) vq.push_back(mk(0, 1,1,0,5+i, 1,1,2,14, 1,0,0,1,0,5+i, 0,0,0));
      vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,1,0,0,0,0, 0,0,0));
      vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));

      // Coprocessor read on its last burst slot returns after the switch to host.
      vq.push_back(mk(1, 0,0,0,0,  1,0,0,0,  0,0,0,0,0,0,  0,0,0));
      vq.push_back(mk(0, 1,1,1,12, 1,0,0,0,  0,1,1,0,0,0,  0,0,0));
      vq.push_back(mk(0, 1,1,1,12, 1,0,0,6,  0,1,1,0,0,6,  0,1,0));
      vq.push_back(mk(0, 1,1,1,12, 1,0,0,12, 0,1,1,0,0,12, 0,1,0));
      vq.push_back(mk(0, 1,1,1,12, 1,0,0,18, 0,1,1,0,0,18, 0,1,0));
      vq.push_back(mk(0, 1,1,1,12, 0,0,0,0,  1,0,0,1,1,12, 0,1,0));
      vq.push_back(mk(0, 0,0,0,0,  0,0,0,0,  1,0,0,0,0,0,  0,0,0));
      vq.push_back(mk(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,0,  0,0,0));

      // Illegal coprocessor matrix: dropped, err next cycle, burst count untouched.
      vq.push_back(mk(1, 0,0,0,0, 1,0,3,0,  0,0,0,0,0,0,  0,0,0));
      vq.push_back(mk(0, 1,1,2,0, 1,0,3,0,  0,1,0,0,0,0,  0,0,0));
      vq.push_back(mk(0, 1,1,2,0, 1,0,1,0,  0,1,1,0,1,0,  0,0,1));
      vq.push_back(mk(0, 1,1,2,0, 1,0,1,6,  0,1,1,0,1,6,  0,1,0));
      vq.push_back(mk(0, 1,1,2,0, 1,0,1,12, 0,1,1,0,1,12, 0,1,0));
      vq.push_back(mk(0, 1,1,2,0, 1,0,1,18, 0,1,1,0,1,18, 0,1,0));
      vq.push_back(mk(0, 1,1,2,0, 0,0,0,0,  1,0,0,1,2,0,  0,1,0));
      vq.push_back(mk(0, 0,0,0,0, 0,0,0,0,  1,0,0,0,0,0,  0,0,0));
      vq.push_back(mk(0, 0,0,0,0, 0,0,0,0,  0,0,0,0,0,0,  0,0,0));

      // Host drops after 2 accesses; coprocessor then gets a full fresh burst of 4.
      vq.push_back(mk(1, 1,1,0,0,  1,1,2,6,  0,0,0,0,0,0,  0,0,0));
      vq.push_back(mk(0, 1,1,0,0,  1,1,2,6,  1,0,0,1,0,0,  0,0,0));
      vq.push_back(mk(0, 1,1,0,6,  1,1,2,6,  1,0,0,1,0,6,  0,0,0));
      vq.push_back(mk(0, 0,0,0,0,  1,1,2,6,  1,0,0,0,0,0,  0,0,0));
      for (int i = 0; i < 4; i++) vq.push_back(mk(0, 1,1,0,12, 1,1,2,6+6*i, 0,1,0,1,2,6+6*i, 0,0,0));
      vq.push_back(mk(0, 1,1,0,12, 0,0,0,0,  1,0,0,1,0,12, 0,0,0));
      vq.push_back(mk(0, 0,0,0,0,  0,0,0,0,  1,0,0,0,0,0,  0,0,0));
      vq.push_back(mk(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,0,  0,0,0));

      // Reset state, with the host already requesting.
      z = mk(0, 1,1,0,0, 1,0,0,0, 0,0,0,0,0,0, 0,0,0);
      drive(z);
      repeat (2) @(negedge in_clk);
      check_vec(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0), -1, '0);
      @(posedge in_clk);
      #1 in_reset = 1'b1;
      drive(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));

      rd_exp = '0;
      for (int i = 0; i < vq.size(); i++) begin
         @(posedge in_clk);
         #1;
         if (vq[i].rst) begin
            in_reset = 1'b0;
            #1 in_reset = 1'b1;
         end
         drive(vq[i]);
         @(negedge in_clk);
         check_vec(vq[i], i, rd_exp);
         rd_exp = vq[i].ren ? data_of(vq[i].em, vq[i].ea) : '0;
      end

      // Reset one cycle after a read: everything drops at once and the pending read is lost.
      @(posedge in_clk);
      #1 in_reset = 1'b0;
      #1 in_reset = 1'b1;
      drive(mk(0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));
      @(negedge in_clk);
      check_vec(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0), 1000, '0);
      @(posedge in_clk);
      #1 drive(mk(0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));
      @(negedge in_clk);
      check_vec(mk(0, 0,0,0,0, 0,0,0,0, 1,0,1,0,0,0, 0,0,0), 1001, '0);
      @(posedge in_clk);
      #1 drive(mk(0, 1,0,0,6, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));
      @(negedge in_clk);
      check_vec(mk(0, 0,0,0,0, 0,0,0,0, 1,0,1,0,0,6, 1,0,0), 1002, data_of(2'd0, 6'd0));
      @(posedge in_clk);
      #1 in_reset = 1'b0;
      #1 check_vec(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0), 1003, '0);
      @(posedge in_clk);
      #1 in_reset = 1'b1;
      drive(mk(0, 1,0,0,0, 1,1,2,0, 0,0,0,0,0,0, 0,0,0));
      @(negedge in_clk);
      check_vec(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0), 1004, '0);
      @(posedge in_clk);
      @(negedge in_clk);
      check_vec(mk(0, 0,0,0,0, 0,0,0,0, 1,0,1,0,0,0, 0,0,0), 1005, '0);
      @(posedge in_clk);
      #1 drive(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/register_file_arbiter.md
Name: register_file_arbiter

Overview:
Arbitrates the single register_file access port between two requesters: the host loader, which preloads and reads back matrices A/B/C, and the square_matrix_mult coprocessor, which fetches operands and writes results.
- Owner switching is round-robin, with bounded bursts.
- Command fields are muxed onto the register_file port.
- Synchronous read data is routed back to whichever requester issued the read.
- Sits between host, coprocessor and register_file, replacing the ad-hoc bus steering done in benches today.

Parameters:
size, 6, matrix dimension
cell_width, 32, bits per cell
width, cell_width*size, row bus width
address_width, $clog2(size*size), register_file address width
max_burst, 4, max consecutive accesses by one owner while the other requests (>=1)

Ports:
in_clk  input  1  clock, rising edge
in_reset  input  1  asynchronous active-low reset
in_h_req  input  1  host requests an access this cycle
in_h_write  input  1  1 = write, 0 = read
in_h_address  input  address_width  host cell/row address
in_h_type  input  2  access type (register_file encoding)
in_h_matrix  input  2  A=00, B=01, C=10; 11 illegal
in_h_data  input  width  host write data
out_h_grant  output  1  host owns the port
out_h_rdata  output  width  read data to host
out_h_rvalid  output  1  out_h_rdata valid
out_h_err  output  1  illegal host command dropped
in_p_req, in_p_write, in_p_address, in_p_type, in_p_matrix, in_p_data  input  as host  coprocessor command
out_p_grant, out_p_rdata, out_p_rvalid, out_p_err  output  as host  coprocessor responses
out_reg_address  output  address_width  to register_file in_address
out_reg_data  output  width  to register_file in_data
out_reg_type  output  2  to register_file in_type
out_reg_matrix  output  2  to register_file in_select_matrix
out_reg_read_en  output  1  to register_file in_read_en
out_reg_write_en  output  1  to register_file in_write_en
in_reg_data  input  width  register_file out_data, valid 1 cycle after read_en

Behaviour:
- Reset (asynchronous, in_reset=0):
  - state IDLE; both grants 0.
  - all out_reg_* 0; all rvalid/err 0; rdata 0.
  - burst counter 0; priority pointer = host.
- State machine: IDLE, OWN_H, OWN_P. Grants are registered: out_x_grant=1 exactly in OWN_X.
- IDLE:
  - Exactly one req -> that requester's OWN state next cycle.
  - Both req -> owner chosen by priority pointer.
  - No req -> stay IDLE.
  - On entry to an OWN state: pointer moves to the other requester; counter cleared.
- OWN_X, with in_x_req=1 and the command legal:
  - Command fields are muxed combinationally to out_reg_* in the same cycle.
  - read_en = ~in_x_write; write_en = in_x_write.
  - Counter increments, saturating at max_burst.
- OWN_X, in_x_req=0:
  - No enable, no count.
  - Next state: other OWN if the other requests, else IDLE.
- Forced switch: when an access makes the count reach max_burst and the other requester's req=1, next state is the other OWN. If the other is idle, the owner keeps the grant.
- Non-owner requests are ignored (no enable, no err) until granted. Requesters hold their command stable until they see grant.
- Illegal command = matrix 11 or type 11:
  - No enable is driven; the access is not counted.
  - out_x_err pulses 1 cycle, registered, i.e. the cycle after.
- Read return:
  - A registered tag of the read issuer is captured with each read.
  - Next cycle: that requester's rvalid=1 and rdata=in_reg_data (combinational pass-through); the other rvalid=0.
  - Routing follows the tag, not the current owner, so a read on the last owned cycle still returns to its issuer after a switch.
  - Throughput: 1 read per cycle, back-to-back.
- rdata when not valid: held at 0.
- Writes need no ack; an access is done in the granted cycle with req=1.
- Unused out_reg_* fields: out_reg_data is 0 on reads and idle cycles; address/type/matrix are 0 when no enable.
- Reset mid-operation: pending read tag discarded (no rvalid after reset); grant dropped immediately.

Test Plan:
- Host alone: rows 0,6,...,30 of A/B/C, type 01, max_burst=4, in_p_req=0 -> grant 1 cycle after req. Host keeps grant for all 18 writes. write_en every cycle with matching address/matrix. Readback rvalid exactly 1 cycle after each read, data equal.
- Both req continuously from reset -> host granted first. Ownership sequence H×4, P×4, H×4. No cycle has both grants. No enable in switch-over cycles.
- Coprocessor read on its 4th burst access, host waiting -> out_p_rvalid=1 with correct row in the first OWN_H cycle; out_h_rvalid=0.
- Coprocessor request with in_p_matrix=11 -> no read_en/write_en. out_p_err=1 for one cycle, the next cycle. Counter unchanged (4 legal accesses still follow).
- in_reset driven low mid-burst, one cycle after a read -> all outputs 0 immediately. No rvalid after release. First grant after release goes to host.
- Host drops req after 2 of 4 accesses while coprocessor waits -> OWN_P next cycle with counter 0.
